// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit queue: byte width and the
// launch FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  // Width of one queued/transmitted byte.
  localparam int BYTE_W = 8;

  // Raw state encodings kept as plain constants for legacy users.
  localparam logic [1:0] LP_IDLE      = 2'd0;
  localparam logic [1:0] LP_LAUNCH    = 2'd1;
  localparam logic [1:0] LP_WAIT_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = LP_IDLE,
    ST_LAUNCH    = LP_LAUNCH,
    ST_WAIT_DONE = LP_WAIT_DONE
  } t_tx_queue_state;

endpackage : uart_pkg

// File: rtl/uart_tx_queue_if.sv
// ---------------------------------------------------------------------------
// uart_tx_queue_if
// Bundles the producer write port, queue status and the transmitter
// handshake of uart_tx_queue.
//   i_Wr_DV/i_Wr_Byte      : producer write strobe and byte
//   o_Full/o_Empty/o_Count : occupancy status
//   o_Overflow             : one-cycle pulse per dropped write
//   o_Busy                 : queue non-empty or launch FSM not idle
//   o_TX_DV/o_TX_Byte      : launch strobe and byte to the transmitter
//   i_TX_Active/i_TX_Done  : transmitter status and completion pulse
//   o_Ovf_Count            : dropped-write counter, only present when
//                            UART_TX_QUEUE_OVF_CNT_EN is defined
// Modports: master = producer/transmitter side, slave = the queue.
// ---------------------------------------------------------------------------
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              i_Wr_DV;
  logic [BYTE_W-1:0] i_Wr_Byte;
  logic              o_Full;
  logic              o_Empty;
  logic [CW-1:0]     o_Count;
  logic              o_Overflow;
  logic              o_Busy;
  logic              o_TX_DV;
  logic [BYTE_W-1:0] o_TX_Byte;
  logic              i_TX_Active;
  logic              i_TX_Done;

`ifdef UART_TX_QUEUE_OVF_CNT_EN
  logic [15:0]       o_Ovf_Count;

  modport master (
    output i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_TX_DV, o_TX_Byte,
    input  o_Ovf_Count
  );

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_TX_DV, o_TX_Byte,
    output o_Ovf_Count
  );
`else
  modport master (
    output i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_TX_DV, o_TX_Byte
  );

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_TX_DV, o_TX_Byte
  );
`endif

endinterface : uart_tx_queue_if

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// DEPTH x 8 circular byte store. Occupancy is tracked by the owner, which
// never writes when full nor reads when empty.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset (pointers only)
//   wr_en_i   : write wr_byte_i at the tail
//   wr_byte_i : byte to store
//   rd_en_i   : advance the head
//   head_o    : byte at the head, read straight out of the storage flops
// ---------------------------------------------------------------------------
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [BYTE_W-1:0] wr_byte_i,
  input  logic              rd_en_i,
  output logic [BYTE_W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;

  // Storage array; contents are meaningless after reset until rewritten.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_byte_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign head_o = mem_q[rd_ptr_q];

endmodule : uart_byte_fifo

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
// Byte queue in front of a UART transmitter. Accepts producer writes,
// drops writes while full, and launches one byte at a time, waiting for
// the transmitter's done pulse before the next launch.
//   i_Clock : clock, all state on rising edge
//   i_Reset : asynchronous active-high reset
//   bus     : uart_tx_queue_if.slave (write port, status, TX handshake)
// Optional: define UART_TX_QUEUE_OVF_CNT_EN to add a saturating 16-bit
// dropped-write counter on bus.o_Ovf_Count.
// ---------------------------------------------------------------------------
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  uart_tx_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  t_tx_queue_state   state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q, ovf_q, busy_q, tx_dv_q;
  logic [BYTE_W-1:0] tx_byte_q;
  logic [BYTE_W-1:0] head_s;
  logic              wr_accept_s, pop_s, launch_s;

  // Full is the registered flag, so a pop in the same cycle never frees room.
  assign wr_accept_s = bus.i_Wr_DV & ~full_q;
  assign pop_s       = (state_q == ST_LAUNCH);

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (i_Clock),
    .rst_i     (i_Reset),
    .wr_en_i   (wr_accept_s),
    .wr_byte_i (bus.i_Wr_Byte),
    .rd_en_i   (pop_s),
    .head_o    (head_s)
  );

  // Launch FSM next state; launch_s marks the IDLE->LAUNCH transition.
  always_comb begin
    state_d  = state_q;
    launch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q && !bus.i_TX_Active) begin
          state_d  = ST_LAUNCH;
          launch_s = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.i_TX_Done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Occupancy next value; write plus pop in one cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({wr_accept_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and status registers; flags derive from next-state values so
  // they line up with o_Count and the FSM state in the same cycle.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= bus.i_Wr_DV & full_q;
      busy_q  <= (count_d != '0) || (state_d != ST_IDLE);
      tx_dv_q <= launch_s;
      if (launch_s) begin
        tx_byte_q <= head_s;
      end
    end
  end

  assign bus.o_Full     = full_q;
  assign bus.o_Empty    = empty_q;
  assign bus.o_Count    = count_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_TX_DV    = tx_dv_q;
  assign bus.o_TX_Byte  = tx_byte_q;

`ifdef UART_TX_QUEUE_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  // Saturating count of dropped writes.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      ovf_cnt_q <= 16'h0000;
    end else if (bus.i_Wr_DV && full_q && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign bus.o_Ovf_Count = ovf_cnt_q;
`else
  // Dropped writes are only signalled through the o_Overflow pulse.
`endif

endmodule : uart_tx_queue

// File: tb/tb_uart_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_queue
// Drives uart_tx_queue (DEPTH=4) with a behavioural UART transmitter and
// receiver (CLKS_PER_BIT=217, 40 ns clock). Expected bytes are queued when
// written and compared when the receiver delivers them.
// ---------------------------------------------------------------------------
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH        = 4;
  localparam int CLKS_PER_BIT = 217;
  localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  uart_tx_queue_if #(.DEPTH(DEPTH)) q_if ();

  uart_tx_queue #(.DEPTH(DEPTH)) u_dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (q_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural UART transmitter.
  logic       tx_serial = 1'b1;
  logic       tx_active = 1'b0;
  logic       tx_done   = 1'b0;
  logic       hold_active = 1'b0;
  logic [9:0] tx_frame  = '0;
  int         tx_cnt = 0;
  int         tx_bit = 0;

  assign q_if.i_TX_Active = tx_active | hold_active;
  assign q_if.i_TX_Done   = tx_done;

  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (!tx_active) begin
      if (q_if.o_TX_DV) begin
        tx_active <= 1'b1;
        tx_frame  <= {1'b1, q_if.o_TX_Byte, 1'b0};
        tx_cnt    <= 0;
        tx_bit    <= 0;
        tx_serial <= 1'b0;
      end
    end else if (tx_cnt < CLKS_PER_BIT - 1) begin
      tx_cnt <= tx_cnt + 1;
    end else begin
      tx_cnt <= 0;
      if (tx_bit == 9) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
        tx_serial <= 1'b1;
      end else begin
        tx_bit    <= tx_bit + 1;
        tx_serial <= tx_frame[tx_bit + 1];
      end
    end
  end

  // Behavioural UART receiver, mid-bit sampling.
  logic       rx_busy = 1'b0;
  logic       rx_dv   = 1'b0;
  logic [7:0] rx_sh   = '0;
  logic [7:0] rx_byte = '0;
  int         rx_cnt = 0;
  int         rx_tgt = 0;
  int         rx_bit = 0;

  always @(posedge clk) begin
    rx_dv <= 1'b0;
    if (!rx_busy) begin
      if (!tx_serial) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 0;
        rx_tgt  <= CLKS_PER_BIT / 2;
        rx_bit  <= 0;
      end
    end else if (rx_cnt != rx_tgt) begin
      rx_cnt <= rx_cnt + 1;
    end else begin
      rx_cnt <= 0;
      rx_tgt <= CLKS_PER_BIT - 1;
      rx_bit <= rx_bit + 1;
      if (rx_bit == 0) begin
        if (tx_serial) rx_busy <= 1'b0;
      end else if (rx_bit <= 8) begin
        rx_sh <= {tx_serial, rx_sh[7:1]};
      end else begin
        rx_busy <= 1'b0;
        rx_dv   <= tx_serial;
        rx_byte <= rx_sh;
      end
    end
  end

  // Scoreboard and protocol monitor.
  logic [7:0] exp_q[$];
  logic       dv_out = 1'b0;
  int         dv_total = 0;
  int         ovf_seen = 0;

  always @(negedge clk) begin
    if (rx_dv) begin
      chk("rx_expected_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("rx_byte", rx_byte, exp_q.pop_front());
    end
    if (q_if.o_TX_DV) begin
      chk("dv_before_done", dv_out & ~tx_done, 1'b0);
      dv_total <= dv_total + 1;
      dv_out   <= 1'b1;
    end else if (tx_done) begin
      dv_out <= 1'b0;
    end
    if (q_if.o_Overflow) ovf_seen <= ovf_seen + 1;
  end

  task automatic wr(input logic [7:0] b, input bit acc);
    q_if.i_Wr_DV   = 1'b1;
    q_if.i_Wr_Byte = b;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    q_if.i_Wr_DV = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || q_if.o_Busy || tx_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_busy", q_if.o_Busy, 1'b0);
    chk("drain_empty", q_if.o_Empty, 1'b1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_count", q_if.o_Count, 0);
    chk("rst_empty", q_if.o_Empty, 1'b1);
    chk("rst_full", q_if.o_Full, 1'b0);
    chk("rst_ovf", q_if.o_Overflow, 1'b0);
    chk("rst_dv", q_if.o_TX_DV, 1'b0);
    chk("rst_busy", q_if.o_Busy, 1'b0);
    chk("rst_byte", q_if.o_TX_Byte, 8'h00);
`ifdef UART_TX_QUEUE_OVF_CNT_EN
    chk("rst_ovf_cnt", q_if.o_Ovf_Count, 16'h0000);
`endif
  endtask

  initial begin
    #3_600_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    int         base;
    bit         seen_idle;
    logic [7:0] rb;
    int         burst_cnt[5] = '{1, 2, 2, 3, 4};

    q_if.i_Wr_DV   = 1'b0;
    q_if.i_Wr_Byte = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Single byte: launch strobe in the cycle after the edge following the write.
    wr(8'h3F, 1'b1);
    chk("single_dv_n", q_if.o_TX_DV, 1'b0);
    chk("single_busy", q_if.o_Busy, 1'b1);
    chk("single_count", q_if.o_Count, 1);
    @(negedge clk);
    chk("single_dv_n1", q_if.o_TX_DV, 1'b1);
    chk("single_byte", q_if.o_TX_Byte, 8'h3F);
    @(negedge clk);
    chk("single_dv_pulse", q_if.o_TX_DV, 1'b0);
    chk("single_byte_hold", q_if.o_TX_Byte, 8'h3F);
    wait_idle(FRAME_CLKS + 500);

    // Burst of five consecutive writes; third write coincides with the first pop.
    for (int i = 0; i < 5; i++) begin
      wr(8'(i + 1), 1'b1);
      chk("burst_count", q_if.o_Count, burst_cnt[i]);
    end
    chk("burst_full", q_if.o_Full, 1'b1);
    wait_idle(5 * FRAME_CLKS + 1000);

    // Overflow with the transmitter held busy.
    hold_active = 1'b1;
    base = ovf_seen;
    for (int i = 0; i < 6; i++) begin
      wr(8'h10 + 8'(i), i < 4);
      chk("ovf_pulse", q_if.o_Overflow, i >= 4);
      chk("ovf_full", q_if.o_Full, i >= 3);
      chk("ovf_count", q_if.o_Count, (i < 4) ? i + 1 : 4);
    end
    @(negedge clk);
    chk("ovf_pulse_gone", q_if.o_Overflow, 1'b0);
    chk("ovf_pulses", ovf_seen - base, 2);
`ifdef UART_TX_QUEUE_OVF_CNT_EN
    chk("ovf_cnt_2", q_if.o_Ovf_Count, 16'd2);
`endif
    // A pop in the same cycle as a write-while-full does not make room.
    hold_active = 1'b0;
    n = 0;
    while (!q_if.o_TX_DV && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_launch_dv", q_if.o_TX_DV, 1'b1);
    wr(8'h99, 1'b0);
    chk("ovf_pop_pulse", q_if.o_Overflow, 1'b1);
    chk("ovf_pop_count", q_if.o_Count, 3);
`ifdef UART_TX_QUEUE_OVF_CNT_EN
    @(negedge clk);
    chk("ovf_cnt_3", q_if.o_Ovf_Count, 16'd3);
`endif
    wait_idle(4 * FRAME_CLKS + 1000);

    // Wrap: 3 x DEPTH random bytes, writes interleaved with launches.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      n = 0;
      while (exp_q.size() >= DEPTH && n < 2 * FRAME_CLKS) begin
        @(negedge clk);
        n++;
      end
      chk("wrap_room", exp_q.size() < DEPTH, 1'b1);
      rb = 8'($urandom_range(0, 255));
      wr(rb, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(3 * DEPTH * FRAME_CLKS + 1000);

    // Reset while the second of three queued bytes is shifting.
    base = dv_total;
    wr(8'hC1, 1'b1);
    wr(8'hC2, 1'b1);
    wr(8'hC3, 1'b1);
    n = 0;
    while ((dv_total - base) < 2 && n < 3 * FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    chk("rst_second_launch", dv_total - base, 2);
    repeat (3 * CLKS_PER_BIT) @(negedge clk);
    chk("rst_frame_inflight", tx_active, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr(8'hA5, 1'b1);
    seen_idle = 1'b0;
    n = 0;
    while (!q_if.o_TX_DV && n < 2 * FRAME_CLKS) begin
      if (!tx_active) seen_idle = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("a5_dv", q_if.o_TX_DV, 1'b1);
    chk("a5_after_tx_idle", seen_idle, 1'b1);
    chk("a5_byte", q_if.o_TX_Byte, 8'hA5);
    wait_idle(2 * FRAME_CLKS + 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_queue

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 16, queue capacity in bytes; SHALL be a power of two, 2..256.
REQ-002 i_Clock  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 i_Reset  in  1  asynchronous, active-high reset.
REQ-004 i_Wr_DV  in  1  one-cycle write strobe from the producer.
REQ-005 i_Wr_Byte  in  8  byte to enqueue; sampled when i_Wr_DV=1.
REQ-006 o_Full  out  1  queue holds DEPTH bytes.
REQ-007 o_Empty  out  1  queue holds zero bytes.
REQ-008 o_Count  out  $clog2(DEPTH)+1  current occupancy.
REQ-009 o_Overflow  out  1  one-cycle pulse when a write is dropped.
REQ-010 o_Busy  out  1  queue non-empty or a byte is in flight on the transmitter.
REQ-011 o_TX_DV  out  1  one-cycle launch strobe to the UART transmitter.
REQ-012 o_TX_Byte  out  8  byte presented with o_TX_DV.
REQ-013 i_TX_Active  in  1  transmitter is shifting a frame.
REQ-014 i_TX_Done  in  1  transmitter one-cycle completion pulse.

Function
REQ-015 A write SHALL be accepted iff i_Wr_DV=1 and o_Full=0 at the sampling edge; the byte goes to the tail and o_Count increments.
REQ-016 A write while o_Full=1 SHALL be discarded, leave the contents unchanged, and pulse o_Overflow in the next cycle; a pop in the same cycle SHALL NOT make room for it.
REQ-017 FSM states SHALL be IDLE, LAUNCH, and WAIT_DONE.
REQ-018 IDLE -> LAUNCH when o_Empty=0 and i_TX_Active=0; otherwise the FSM SHALL stay in IDLE.
REQ-019 In LAUNCH, o_TX_DV=1 for exactly one cycle, o_TX_Byte=head byte, the head is popped, and the FSM SHALL go unconditionally to WAIT_DONE.
REQ-020 WAIT_DONE -> IDLE on i_TX_Done=1; a new o_TX_DV SHALL never be issued before the previous i_TX_Done.
REQ-021 o_TX_Byte SHALL hold its value from a LAUNCH until the next LAUNCH.
REQ-022 Latency: a write accepted at edge N into an empty queue with the transmitter idle SHALL produce o_TX_DV high in the cycle after edge N+1.
REQ-023 Simultaneous accepted write and LAUNCH pop SHALL leave o_Count unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-024 Bytes SHALL leave in strict FIFO order with no duplication or loss.
REQ-025 o_Busy = (o_Empty=0) or (state != IDLE).

Reset
REQ-026 i_Reset=1 SHALL immediately force the FSM to IDLE, the pointers and o_Count to 0, o_Empty=1, and o_Full, o_Overflow, o_TX_DV, o_Busy and o_TX_Byte to 0.
REQ-027 Reset mid-frame SHALL discard all queued bytes; a frame already launched on the transmitter is not aborted, and after reset release the FSM SHALL wait for i_TX_Active=0 before the next launch.

Configuration
REQ-028 With UART_TX_QUEUE_OVF_CNT_EN defined, an extra output o_Ovf_Count [15:0] SHALL count dropped writes, saturate at 16'hFFFF, and clear on reset.
REQ-029 With UART_TX_QUEUE_OVF_CNT_EN undefined, the o_Ovf_Count port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state enum (t_tx_queue_state) and the constant for the 8-bit byte width.
REQ-031 Storage SHALL be a sub-module uart_byte_fifo (DEPTH x 8, synchronous write, registered head output); uart_tx_queue SHALL own the FSM and the status outputs.

Verification
REQ-032 Bench: CLKS_PER_BIT=217, 40 ns clock, real UART_TX and UART_RX connected; UART_RX output checked.
REQ-033 Single byte: write 8'h3F into an idle, empty queue -> o_TX_DV exactly 2 edges later, and UART_RX receives 8'h3F.
REQ-034 Burst: write 8'h01..8'h05 on consecutive clocks -> five frames received in order, one o_TX_DV per i_TX_Done, o_Empty=1 at the end.
REQ-035 Overflow (DEPTH=4, transmitter held active): 6 writes -> o_Full=1, two o_Overflow pulses, o_Count=4, and o_Ovf_Count=2 when the macro is enabled.
REQ-036 Wrap: 3 x DEPTH bytes with a pseudo-random pattern, interleaved writes and launches -> the received stream matches exactly.
REQ-037 Reset mid-frame: assert i_Reset while the 2nd of 3 queued bytes is shifting -> outputs reach their reset values at once, the 3rd byte is never sent, and the next written byte 8'hA5 launches only after i_TX_Active falls.
